// File: rtl/nn_pkg.sv
// nn_pkg: sequencer FSM states and width helpers shared by the MAC sequencer files.
package nn_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, SETTLE, OUT, FIN} seq_state_t;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: per-neuron result handshake (word, neuron index, valid/ready).
interface mac_sequencer_if #(
    parameter int BIT_SIZE = 16,
    parameter int NEURONS  = 8
);
    import nn_pkg::*;
    logic [BIT_SIZE-1:0]         out_data;
    logic [addr_w(NEURONS)-1:0]  out_idx;
    logic                        out_valid;
    logic                        out_ready;
    modport master (output out_data, out_idx, out_valid, input out_ready);
    modport slave  (input out_data, out_idx, out_valid, output out_ready);
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: walks one layer, streaming x/w pairs into an external MAC
// and handing out one clamped result per neuron over a valid/ready handshake.
module mac_sequencer
    import nn_pkg::*;
#(
    parameter int  SIZE     = 16,
    parameter int  NEURONS  = 8,
    parameter int  BIT_SIZE = 16,
    localparam int NW = cnt_w(SIZE),
    localparam int MW = cnt_w(NEURONS),
    localparam int XW = addr_w(SIZE),
    localparam int JW = addr_w(NEURONS),
    localparam int WW = addr_w(SIZE * NEURONS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NW-1:0]       cfg_n_in,
    input  logic [MW-1:0]       cfg_n_out,
    output logic [XW-1:0]       x_addr,
    output logic [WW-1:0]       w_addr,
    output logic                rd_en,
    input  logic [BIT_SIZE-1:0] x_data,
    input  logic [BIT_SIZE-1:0] w_data,
    output logic [BIT_SIZE-1:0] mac_x,
    output logic [BIT_SIZE-1:0] mac_w,
    output logic                mac_en,
    output logic                mac_clr,
    input  logic [BIT_SIZE-1:0] mac_y,
    mac_sequencer_if.master     out_if,
    output logic                busy,
    output logic                done
);
    seq_state_t          r_state, w_next;
    logic [NW-1:0]       r_n_in, w_n_in_sat;
    logic [MW-1:0]       r_n_out, w_n_out_sat;
    logic [XW-1:0]       r_i;
    logic [JW-1:0]       r_j, r_out_idx;
    logic [BIT_SIZE-1:0] r_mac_x, r_mac_w, r_out_data;
    logic                r_mac_en;
    logic                w_last_i, w_last_j;

    assign w_n_in_sat  = (cfg_n_in > NW'(SIZE)) ? NW'(SIZE) : cfg_n_in;
    assign w_n_out_sat = (cfg_n_out > MW'(NEURONS)) ? MW'(NEURONS) : cfg_n_out;
    assign w_last_i    = NW'(r_i) == r_n_in - NW'(1);
    assign w_last_j    = MW'(r_j) == r_n_out - MW'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !start ? IDLE : ((w_n_out_sat == '0) ? FIN : CLEAR);
            CLEAR:   w_next = (r_n_in == '0) ? SETTLE : FEED;
            FEED:    w_next = w_last_i ? DRAIN : FEED;
            DRAIN:   w_next = SETTLE;
            SETTLE:  w_next = OUT;
            OUT:     w_next = !out_if.out_ready ? OUT : (w_last_j ? FIN : CLEAR);
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_n_in     <= '0;
            r_n_out    <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_mac_en   <= 1'b0;
            r_mac_x    <= '0;
            r_mac_w    <= '0;
            r_out_data <= '0;
            r_out_idx  <= '0;
        end else begin
            r_state  <= w_next;
            // read data is taken on the edge closing the read cycle, so the MAC sees it one cycle later
            r_mac_en <= rd_en;
            r_mac_x  <= rd_en ? x_data : '0;
            r_mac_w  <= rd_en ? w_data : '0;
            if (r_state == IDLE && start) begin
                r_n_in  <= w_n_in_sat;
                r_n_out <= w_n_out_sat;
                r_j     <= '0;
            end
            if (r_state == CLEAR) r_i <= '0;
            if (rd_en) r_i <= r_i + 1'b1;
            if (r_state == SETTLE) begin
                r_out_data <= mac_y;
                r_out_idx  <= r_j;
            end
            if (r_state == OUT && out_if.out_ready && !w_last_j) r_j <= r_j + 1'b1;
        end
    end

    assign rd_en            = r_state == FEED;
    assign x_addr           = rd_en ? r_i : '0;
    assign w_addr           = rd_en ? WW'(r_j) * WW'(r_n_in) + WW'(r_i) : '0;
    assign mac_x            = r_mac_x;
    assign mac_w            = r_mac_w;
    assign mac_en           = r_mac_en;
    assign mac_clr          = rst || r_state == CLEAR;
    assign busy             = r_state != IDLE;
    assign done             = r_state == FIN;
    assign out_if.out_valid = r_state == OUT;
    assign out_if.out_data  = r_out_data;
    assign out_if.out_idx   = r_out_idx;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: drives layers through the sequencer with a behavioural memory and MAC,
// comparing each neuron result against a dot-product-and-clamp reference.
module tb_mac_sequencer;
    import nn_pkg::*;
    localparam int SIZE = 16, NEURONS = 8, BIT_SIZE = 16;
    localparam int NW = $clog2(SIZE + 1), MW = $clog2(NEURONS + 1);
    localparam int XW = $clog2(SIZE), WW = $clog2(SIZE * NEURONS);

    logic clk = 1'b0, rst, start;
    logic [NW-1:0] cfg_n_in;
    logic [MW-1:0] cfg_n_out;
    logic [XW-1:0] x_addr;
    logic [WW-1:0] w_addr;
    logic rd_en, mac_en, mac_clr, busy, done;
    logic [BIT_SIZE-1:0] x_data, w_data, mac_x, mac_w, mac_y;
    logic [BIT_SIZE-1:0] xmem [SIZE];
    logic [BIT_SIZE-1:0] wmem [SIZE*NEURONS];
    logic [47:0] acc;

    int checks = 0, failures = 0;
    int r_cnt, m_cnt, c_cnt, d_cnt, d_at, m_stray, stall_bad, stall_seen, tmo, post_busy, post_done;
    int q_data[$], q_idx[$], q_lat[$], mac_per[$];

    mac_sequencer_if #(.BIT_SIZE(BIT_SIZE), .NEURONS(NEURONS)) out_if ();

    mac_sequencer #(.SIZE(SIZE), .NEURONS(NEURONS), .BIT_SIZE(BIT_SIZE)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_n_in(cfg_n_in), .cfg_n_out(cfg_n_out),
        .x_addr(x_addr), .w_addr(w_addr), .rd_en(rd_en), .x_data(x_data), .w_data(w_data),
        .mac_x(mac_x), .mac_w(mac_w), .mac_en(mac_en), .mac_clr(mac_clr), .mac_y(mac_y),
        .out_if(out_if), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // memory word for the presented address is taken by the sequencer on the edge after rd_en
    assign x_data = xmem[x_addr];
    assign w_data = wmem[w_addr];
    always @(posedge clk) acc <= mac_clr ? '0 : (mac_en ? acc + 48'(mac_x) * 48'(mac_w) : acc);
    assign mac_y = (acc > 48'hFFFF) ? 16'hFFFF : acc[15:0];

    function automatic int ref_out(input int j, input int nin);
        longint s = 0;
        for (int i = 0; i < nin; i++) s += longint'(xmem[i]) * longint'(wmem[j*nin+i]);
        return (s > 65535) ? 65535 : int'(s);
    endfunction

    task automatic fill_mem(input int maxv);
        for (int i = 0; i < SIZE; i++) xmem[i] = BIT_SIZE'($urandom_range(0, maxv));
        for (int i = 0; i < SIZE*NEURONS; i++) wmem[i] = BIT_SIZE'($urandom_range(0, maxv));
    endtask

    task automatic run_layer(input int nin, input int nout, input int stall, input bit noisy);
        int cyc = 0, clr_at = 0, left = 0, held = 0;
        bit in_out = 0;
        r_cnt = 0; m_cnt = 0; c_cnt = 0; d_cnt = 0; d_at = -1; m_stray = 0;
        stall_bad = 0; stall_seen = 0; tmo = 0;
        q_data.delete(); q_idx.delete(); q_lat.delete(); mac_per.delete();
        @(negedge clk);
        start = 1'b1; cfg_n_in = NW'(nin); cfg_n_out = MW'(nout); out_if.out_ready = 1'b1;
        while (d_cnt == 0 && tmo == 0) begin
            @(negedge clk);
            cyc++;
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) begin
                cfg_n_in = NW'($urandom);
                cfg_n_out = MW'($urandom);
            end
            if (mac_clr) begin
                c_cnt++;
                clr_at = cyc;
                mac_per.push_back(0);
            end
            if (rd_en) r_cnt++;
            if (mac_en) begin
                m_cnt++;
                if (mac_per.size() == 0) m_stray++;
                else mac_per[mac_per.size()-1]++;
            end
            if (out_if.out_valid) begin
                if (!in_out) begin
                    in_out = 1;
                    left = stall;
                    held = int'(out_if.out_data);
                    q_lat.push_back(cyc - clr_at);
                end
                if (out_if.out_data !== BIT_SIZE'(held) || rd_en || mac_en) stall_bad++;
                out_if.out_ready = (left == 0);
                if (left > 0) begin
                    left--;
                    stall_seen++;
                end else begin
                    q_data.push_back(int'(out_if.out_data));
                    q_idx.push_back(int'(out_if.out_idx));
                    in_out = 0;
                end
            end else out_if.out_ready = 1'b1;
            if (done) begin
                d_cnt++;
                d_at = cyc;
            end
            if (cyc > 3000) tmo = 1;
        end
        start = 1'b0;
        @(negedge clk);
        post_busy = int'(busy);
        post_done = int'(done);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; cfg_n_in = 3; cfg_n_out = 2; out_if.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mac_clr !== 1'b1) begin failures++; $display("FAIL rst_mac_clr: got %b want 1", mac_clr); end
        checks++;
        if ({busy, done, out_if.out_valid, rd_en, mac_en} !== 5'b0) begin
            failures++; $display("FAIL rst_flags: got %b want 00000", {busy, done, out_if.out_valid, rd_en, mac_en});
        end
        checks++;
        if ({out_if.out_data, out_if.out_idx, mac_x, mac_w, x_addr, w_addr} !== '0) begin
            failures++; $display("FAIL rst_data: got %h want 0", {out_if.out_data, out_if.out_idx, mac_x, mac_w, x_addr, w_addr});
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mac_clr !== 1'b0) begin
            failures++; $display("FAIL rst_priority: got busy=%b clr=%b want 0 0", busy, mac_clr);
        end
    endtask

    task automatic test_directed;
        int exp_d[2] = '{6, 5};
        for (int i = 0; i < SIZE; i++) xmem[i] = '0;
        for (int i = 0; i < SIZE*NEURONS; i++) wmem[i] = '0;
        xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
        wmem[0] = 1; wmem[1] = 1; wmem[2] = 1; wmem[3] = 2; wmem[4] = 0; wmem[5] = 1;
        run_layer(3, 2, 0, 0);
        checks++;
        if (tmo != 0 || d_cnt != 1 || q_data.size() != 2) begin
            failures++; $display("FAIL dir_count: got outs=%0d done=%0d tmo=%0d want 2 1 0", q_data.size(), d_cnt, tmo);
        end
        for (int j = 0; j < q_data.size() && j < 2; j++) begin
            checks++;
            if (q_data[j] != exp_d[j] || q_idx[j] != j || q_lat[j] != 6) begin
                failures++; $display("FAIL dir_out%0d: got idx%0d,%0d lat %0d want idx%0d,%0d lat 6", j, q_idx[j], q_data[j], q_lat[j], j, exp_d[j]);
            end
        end
        checks++;
        if (r_cnt != 6 || m_cnt != 6 || m_stray != 0 || mac_per.size() != 2 || mac_per[0] != 3 || mac_per[1] != 3) begin
            failures++; $display("FAIL dir_mac: got rd=%0d mac=%0d stray=%0d want 6 6 0 (3 per neuron)", r_cnt, m_cnt, m_stray);
        end
        checks++;
        if (post_busy != 0 || post_done != 0) begin
            failures++; $display("FAIL dir_done_pulse: got busy=%0d done=%0d after pulse want 0 0", post_busy, post_done);
        end
    endtask

    task automatic test_stall;
        fill_mem(255);
        run_layer(4, 3, 5, 0);
        checks++;
        if (tmo != 0 || q_data.size() != 3 || stall_seen != 15 || stall_bad != 0) begin
            failures++; $display("FAIL stall_hold: got outs=%0d stalled=%0d bad=%0d want 3 15 0", q_data.size(), stall_seen, stall_bad);
        end
        for (int j = 0; j < q_data.size(); j++) begin
            checks++;
            if (q_data[j] != ref_out(j, 4) || q_idx[j] != j) begin
                failures++; $display("FAIL stall_out%0d: got idx%0d,%0d want idx%0d,%0d", j, q_idx[j], q_data[j], j, ref_out(j, 4));
            end
        end
    endtask

    task automatic test_zero_in;
        fill_mem(255);
        run_layer(0, 1, 0, 0);
        checks++;
        if (tmo != 0 || c_cnt != 1 || m_cnt != 0 || r_cnt != 0 || d_cnt != 1) begin
            failures++; $display("FAIL zin_flow: got clr=%0d mac=%0d rd=%0d done=%0d want 1 0 0 1", c_cnt, m_cnt, r_cnt, d_cnt);
        end
        checks++;
        if (q_data.size() != 1 || q_data[0] != 0 || q_idx[0] != 0) begin
            failures++; $display("FAIL zin_out: got %0d outputs, first=%0d want one output idx0,0", q_data.size(), (q_data.size() > 0) ? q_data[0] : -1);
        end
    endtask

    task automatic test_zero_out;
        run_layer(5, 0, 0, 0);
        checks++;
        if (tmo != 0 || d_at != 1 || r_cnt != 0 || q_data.size() != 0 || post_done != 0) begin
            failures++; $display("FAIL zout: got done_at=%0d rd=%0d outs=%0d want 1 0 0", d_at, r_cnt, q_data.size());
        end
    endtask

    task automatic test_saturate;
        fill_mem(255);
        run_layer(20, 12, 0, 0);
        checks++;
        if (tmo != 0 || q_data.size() != NEURONS || r_cnt != SIZE*NEURONS || m_cnt != SIZE*NEURONS) begin
            failures++; $display("FAIL sat_count: got outs=%0d rd=%0d mac=%0d want %0d %0d %0d", q_data.size(), r_cnt, m_cnt, NEURONS, SIZE*NEURONS, SIZE*NEURONS);
        end
        for (int j = 0; j < q_data.size(); j++) begin
            checks++;
            if (q_data[j] != ref_out(j, SIZE) || q_idx[j] != j || q_lat[j] != SIZE + 3) begin
                failures++; $display("FAIL sat_out%0d: got idx%0d,%0d lat %0d want idx%0d,%0d lat %0d", j, q_idx[j], q_data[j], q_lat[j], j, ref_out(j, SIZE), SIZE + 3);
            end
        end
    endtask

    task automatic test_reset_mid_feed;
        int cyc = 0;
        fill_mem(63);
        @(negedge clk);
        start = 1'b1; cfg_n_in = 5; cfg_n_out = 2;
        @(negedge clk);
        start = 1'b0;
        while (!(rd_en && x_addr == 2) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!(rd_en && x_addr == 2)) begin failures++; $display("FAIL mfeed_reach: got rd=%b x_addr=%0d want 1 2", rd_en, x_addr); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, out_if.out_valid, rd_en, mac_en, mac_clr} !== 6'b000001) begin
            failures++; $display("FAIL mfeed_flags: got %b want 000001", {busy, done, out_if.out_valid, rd_en, mac_en, mac_clr});
        end
        checks++;
        if ({out_if.out_data, out_if.out_idx, mac_x, mac_w, x_addr, w_addr} !== '0) begin
            failures++; $display("FAIL mfeed_data: got %h want 0", {out_if.out_data, out_if.out_idx, mac_x, mac_w, x_addr, w_addr});
        end
        rst = 1'b0;
        run_layer(4, 3, 0, 0);
        checks++;
        if (tmo != 0 || d_cnt != 1 || q_data.size() != 3 || m_cnt != 12) begin
            failures++; $display("FAIL mfeed_rerun: got outs=%0d mac=%0d done=%0d want 3 12 1", q_data.size(), m_cnt, d_cnt);
        end
        for (int j = 0; j < q_data.size(); j++) begin
            checks++;
            if (q_data[j] != ref_out(j, 4) || q_idx[j] != j) begin
                failures++; $display("FAIL mfeed_out%0d: got idx%0d,%0d want idx%0d,%0d", j, q_idx[j], q_data[j], j, ref_out(j, 4));
            end
        end
    endtask

    task automatic test_busy_start;
        fill_mem(255);
        run_layer(6, 4, 1, 1);
        checks++;
        if (tmo != 0 || d_cnt != 1 || c_cnt != 4 || q_data.size() != 4 || m_cnt != 24) begin
            failures++; $display("FAIL busy_flow: got outs=%0d clr=%0d mac=%0d want 4 4 24", q_data.size(), c_cnt, m_cnt);
        end
        for (int j = 0; j < q_data.size(); j++) begin
            checks++;
            if (q_data[j] != ref_out(j, 6) || q_idx[j] != j) begin
                failures++; $display("FAIL busy_out%0d: got idx%0d,%0d want idx%0d,%0d", j, q_idx[j], q_data[j], j, ref_out(j, 6));
            end
        end
        checks++;
        if (post_busy != 0) begin failures++; $display("FAIL busy_idle: got busy=%0d want 0", post_busy); end
    endtask

    task automatic test_random;
        for (int t = 0; t < 6; t++) begin
            int nin = $urandom_range(1, SIZE);
            int nout = $urandom_range(1, NEURONS);
            int bad = 0;
            fill_mem($urandom_range(0, 1) ? 255 : 31);
            run_layer(nin, nout, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            checks++;
            if (tmo != 0 || d_cnt != 1 || q_data.size() != nout || stall_bad != 0) begin
                failures++; $display("FAIL rnd%0d_flow: got outs=%0d done=%0d bad=%0d want %0d 1 0", t, q_data.size(), d_cnt, stall_bad, nout);
            end
            for (int k = 0; k < mac_per.size(); k++) if (mac_per[k] != nin) bad++;
            checks++;
            if (m_stray != 0 || bad != 0 || m_cnt != nin*nout || r_cnt != nin*nout) begin
                failures++; $display("FAIL rnd%0d_mac: got mac=%0d rd=%0d bad_neurons=%0d want %0d each", t, m_cnt, r_cnt, bad, nin*nout);
            end
            for (int j = 0; j < q_data.size(); j++) begin
                checks++;
                if (q_data[j] != ref_out(j, nin) || q_idx[j] != j || q_lat[j] != nin + 3) begin
                    failures++; $display("FAIL rnd%0d_out%0d: got idx%0d,%0d lat %0d want idx%0d,%0d lat %0d", t, j, q_idx[j], q_data[j], q_lat[j], j, ref_out(j, nin), nin + 3);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_stall;
        test_zero_in;
        test_zero_out;
        test_saturate;
        test_reset_mid_feed;
        test_busy_start;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 16; the maximum number of inputs per neuron (N).
REQ-002 SHALL have parameter NEURONS, default 8; the maximum number of neurons per layer (M).
REQ-003 SHALL have parameter BIT_SIZE, default 16; the data and weight word width.
REQ-004 SHALL have port clk, input, 1 bit; the single clock.
REQ-005 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit; a one-cycle layer start pulse.
REQ-007 SHALL have port cfg_n_in, input, $clog2(SIZE+1) bits; the input count, latched at start.
REQ-008 SHALL have port cfg_n_out, input, $clog2(NEURONS+1) bits; the neuron count, latched at start.
REQ-009 SHALL have port x_addr, output, $clog2(SIZE) bits; the input-vector memory address.
REQ-010 SHALL have port w_addr, output, $clog2(SIZE*NEURONS) bits; the weight memory address.
REQ-011 SHALL have port rd_en, output, 1 bit; the read strobe for both memories.
REQ-012 SHALL have ports x_data and w_data, input, BIT_SIZE bits each; read data, valid 1 cycle after rd_en.
REQ-013 SHALL have ports mac_x and mac_w, output, BIT_SIZE bits each; operands to the MAC neuron.
REQ-014 SHALL have port mac_en, output, 1 bit; the MAC accumulates mac_x*mac_w this cycle.
REQ-015 SHALL have port mac_clr, output, 1 bit; clears the MAC accumulator.
REQ-016 SHALL have port mac_y, input, BIT_SIZE bits; the clamped accumulator from the MAC.
REQ-017 SHALL have ports out_data, output, BIT_SIZE bits, and out_idx, output, $clog2(NEURONS) bits; the result word and its neuron index.
REQ-018 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit; the result handshake.
REQ-019 SHALL have ports busy and done, output, 1 bit each; done is a one-cycle pulse at layer end.

Function
REQ-020 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, SETTLE, OUT and FIN.
REQ-021 SHALL, in IDLE, on start latch cfg_n_in/cfg_n_out, zero the neuron index j, and go to CLEAR; if cfg_n_out==0, go to FIN instead.
REQ-022 SHALL ignore start whenever busy=1.
REQ-023 SHALL, in CLEAR, assert mac_clr for exactly 1 cycle and zero the input index i; next state is FEED, or SETTLE if n_in==0.
REQ-024 SHALL, in FEED, assert rd_en with x_addr=i and w_addr=j*n_in+i, incrementing i each cycle; after i==n_in-1, go to DRAIN.
REQ-025 SHALL register x_data/w_data onto mac_x/mac_w with mac_en=1 the cycle after each rd_en, so exactly n_in mac_en pulses occur per neuron and none occur outside them.
REQ-026 SHALL, in DRAIN, issue the final mac_en (1 cycle), then move to SETTLE.
REQ-027 SHALL, in SETTLE, wait 1 cycle so the MAC commits the last term, then capture mac_y into out_data and j into out_idx, and go to OUT.
REQ-028 SHALL, in OUT, hold out_valid=1 with out_data/out_idx stable until out_valid&&out_ready; on that handshake, increment j and go to CLEAR, or go to FIN if j==n_out-1.
REQ-029 SHALL accept out_ready=1 on the first OUT cycle, giving zero stall.
REQ-030 SHALL, in FIN, pulse done=1 for 1 cycle and return to IDLE.
REQ-031 SHALL hold busy=1 in every state except IDLE.
REQ-032 SHALL compute w_addr with full-width unsigned arithmetic and no wrap for n_in<=SIZE and n_out<=NEURONS.
REQ-033 SHALL saturate cfg values above SIZE/NEURONS to SIZE/NEURONS at latch.
REQ-034 SHALL, for per-neuron latency with no stall, take n_in+3 cycles from CLEAR entry to out_valid.

Reset
REQ-035 SHALL, on rst, return synchronously to IDLE from any state, including mid-FEED and mid-OUT.
REQ-036 SHALL, on rst, set busy, done, out_valid, rd_en, mac_en, out_data, out_idx, mac_x, mac_w, x_addr, w_addr, i, j and the latched cfg values to 0, and set mac_clr=1 for that cycle.
REQ-037 SHALL give rst priority over a simultaneous start.

Structure
REQ-038 SHALL place the FSM state enum and the address-width helper constants in the shared package nn_pkg.
REQ-039 SHALL keep the FSM, counters and address generation in a single module with no sub-module; the MAC neuron is instantiated by the parent, not inside this block.

Verification
REQ-040 SHALL cover: n_in=3, n_out=2, x={1,2,3}, w={1,1,1, 2,0,1}, out_ready=1 -> outputs (idx0,6), (idx1,5), then done; latency n_in+3 per neuron.
REQ-041 SHALL cover: out_ready=0 for 5 cycles in OUT -> out_valid and out_data held stable, no rd_en or mac_en, then proceeds on ready.
REQ-042 SHALL cover: n_in=0, n_out=1 -> mac_clr, no mac_en, output (idx0,0), done.
REQ-043 SHALL cover: n_out=0 -> done pulse 1 cycle after start, no rd_en.
REQ-044 SHALL cover: rst asserted mid-FEED at i=2 -> next cycle IDLE with all outputs 0; a new start runs a clean layer.
REQ-045 SHALL cover: start pulsed while busy -> ignored, and the layer result is unchanged.
